dram_peek_bridge: RTL

//  Sits downstream of the SPI CSR controller's DRAM peek/poke port (dram0_*). Turns its single-word

---
 rtl/dram_peek_bridge_if.sv | 54 +++++
 rtl/dram_peek_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dram_peek_bridge_if.sv
// Bundles the SPI peek/poke request side and the MCB-style DRAM user port.
// Modports:
//   master - used by the bridge: takes requests and FIFO flags, drives acks and DRAM strobes.
//   slave  - used by the environment: drives requests and FIFO flags, observes the bridge.
// Request side : addr_i, data_i, we_i, pop_i -> data_o, ack_o, busy_o, collide_o, timeout_o
// DRAM side    : p_cmd_*, p_wr_*, p_rd_* (cmd / write FIFO / read FIFO)
interface dram_peek_bridge_if #(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned BADDR_WIDTH = 30
);
  logic [ADDR_WIDTH-1:0]  addr_i;
  logic [31:0]            data_i;
  logic                   we_i;
  logic                   pop_i;
  logic [31:0]            data_o;
  logic                   ack_o;
  logic                   busy_o;
  logic                   collide_o;
  logic                   timeout_o;
  logic                   p_cmd_en;
  logic [2:0]             p_cmd_instr;
  logic [5:0]             p_cmd_bl;
  logic [BADDR_WIDTH-1:0] p_cmd_byte_addr;
  logic                   p_cmd_full;
  logic                   p_wr_en;
  logic [3:0]             p_wr_mask;
  logic [31:0]            p_wr_data;
  logic                   p_wr_full;
  logic                   p_rd_en;
  logic [31:0]            p_rd_data;
  logic                   p_rd_empty;

  modport master (
    input  addr_i, data_i, we_i, pop_i,
    output data_o, ack_o, busy_o, collide_o, timeout_o,
    output p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
    input  p_cmd_full,
    output p_wr_en, p_wr_mask, p_wr_data,
    input  p_wr_full,
    output p_rd_en,
    input  p_rd_data, p_rd_empty
  );

  modport slave (
    output addr_i, data_i, we_i, pop_i,
    input  data_o, ack_o, busy_o, collide_o, timeout_o,
    input  p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
    output p_cmd_full,
    input  p_wr_en, p_wr_mask, p_wr_data,
    output p_wr_full,
    input  p_rd_en,
    output p_rd_data, p_rd_empty
  );
endinterface

// File: rtl/dram_peek_bridge.sv
// Converts single-word peek (pop_i) / poke (we_i) pulses into commands on a 32-bit MCB-style
// DRAM user port, one transaction outstanding at a time, and returns ack_o plus read data.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   bus      - dram_peek_bridge_if.master: request side (addr_i, data_i, we_i, pop_i, data_o,
//              ack_o, busy_o, collide_o, timeout_o) and DRAM side (p_cmd_*, p_wr_*, p_rd_*)
// Optional feature: define DRAM_PEEK_BRIDGE_TIMEOUT_EN to bound every FIFO wait to
// TIMEOUT_CYCLES cycles; otherwise waits are unbounded and timeout_o is tied low.
module dram_peek_bridge #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned BADDR_WIDTH    = 30,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                clk,
  input logic                rst,
  dram_peek_bridge_if.master bus
);

  if (BADDR_WIDTH != ADDR_WIDTH + 2 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536)
  begin : g_param_check
    $error("dram_peek_bridge: bad parameters");
  end

  localparam logic [2:0] InstrWrite = 3'b000;
  localparam logic [2:0] InstrRead  = 3'b001;

  typedef enum logic [2:0] {StIdle, StWrData, StWrCmd, StRdCmd, StRdWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  collide_q, collide_d;
  logic                  accept, load_wr;
  logic                  cmd_en, wr_en, rd_en, ack;
  logic [2:0]            cmd_instr;
  logic                  expired;
  logic                  timeout_set;

`ifdef DRAM_PEEK_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
  logic        timeout_q;
  logic        waiting;

  assign waiting = (state_q == StWrData) || (state_q == StWrCmd) ||
                   (state_q == StRdCmd)  || (state_q == StRdWait);
  assign expired = (wait_q == WaitLast);
  // Any state change restarts the count, so it measures time stuck in one wait state.
  assign wait_d  = (!waiting || state_d != state_q) ? 16'd0 : wait_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (accept) begin
        timeout_q <= 1'b0;
      end else if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign expired       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_en      = 1'b0;
    cmd_instr   = InstrWrite;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    ack         = 1'b0;
    accept      = 1'b0;
    load_wr     = 1'b0;
    rdata_d     = rdata_q;
    collide_d   = collide_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.we_i) begin
          state_d = StWrData;
          accept  = 1'b1;
          load_wr = 1'b1;
        end else if (bus.pop_i) begin
          state_d = StRdCmd;
          accept  = 1'b1;
        end else if (!bus.p_rd_empty) begin
          // Discard a word left over from a read aborted by reset or timeout.
          rd_en = 1'b1;
        end
        if (bus.we_i || bus.pop_i) begin
          collide_d = bus.we_i & bus.pop_i;
        end
      end
      StWrData: begin
        if (!bus.p_wr_full) begin
          wr_en   = 1'b1;
          state_d = StWrCmd;
        end else if (expired) begin
          timeout_set = 1'b1;
          state_d     = StAck;
        end
      end
      StWrCmd: begin
        if (!bus.p_cmd_full) begin
          cmd_en  = 1'b1;
          state_d = StAck;
        end else if (expired) begin
          timeout_set = 1'b1;
          state_d     = StAck;
        end
      end
      StRdCmd: begin
        cmd_instr = InstrRead;
        if (!bus.p_cmd_full) begin
          cmd_en  = 1'b1;
          state_d = StRdWait;
        end else if (expired) begin
          timeout_set = 1'b1;
          rdata_d     = 32'hDEADBEEF;
          state_d     = StAck;
        end
      end
      StRdWait: begin
        cmd_instr = InstrRead;
        if (!bus.p_rd_empty) begin
          rd_en   = 1'b1;
          rdata_d = bus.p_rd_data;
          state_d = StAck;
        end else if (expired) begin
          timeout_set = 1'b1;
          rdata_d     = 32'hDEADBEEF;
          state_d     = StAck;
        end
      end
      StAck: begin
        ack     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      collide_q <= collide_d;
      if (accept) begin
        addr_q <= bus.addr_i;
      end
      if (load_wr) begin
        data_q <= bus.data_i;
      end
    end
  end

  assign bus.data_o          = rdata_q;
  assign bus.ack_o           = ack;
  assign bus.busy_o          = (state_q != StIdle);
  assign bus.collide_o       = collide_q;
  assign bus.p_cmd_en        = cmd_en;
  assign bus.p_cmd_instr     = cmd_instr;
  assign bus.p_cmd_bl        = 6'd0;
  assign bus.p_cmd_byte_addr = {addr_q, 2'b00};
  assign bus.p_wr_en         = wr_en;
  assign bus.p_wr_mask       = 4'b0000;
  assign bus.p_wr_data       = data_q;
  assign bus.p_rd_en         = rd_en;

endmodule
